// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared constants for the data-memory / MMIO stage
package dmem_mmio_pkg;

    // I/O register offsets, decoded on addr[3:2]
    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_CYCLE  = 2'd1;
    localparam logic [1:0] OFF_TXDATA = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/dmem_mmio_uart_tx_fsm.sv
// rtl/dmem_mmio_uart_tx_fsm.sv - 8N1 UART transmitter, start ignored while busy
module uart_tx_fsm
    import dmem_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [BW-1:0] baud, baud_n;
    logic          baud_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            baud   <= '0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            bitcnt <= bitcnt_n;
            baud   <= baud_n;
        end
    end

    // tx and busy decode straight from state so reset forces the line idle at once
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bitcnt_n  = bitcnt;
        baud_n    = baud;
        tx        = 1'b1;
        busy      = 1'b1;
        baud_last = (baud == BAUD_LAST);
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    shreg_n  = data;
                    bitcnt_n = '0;
                    baud_n   = '0;
                    state_n  = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            DATA: begin
                tx = shreg[0];
                if (baud_last) begin
                    baud_n  = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bitcnt == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bitcnt_n = bitcnt + 3'd1;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM plus LED / cycle counter / UART I/O page
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          RAM_AW       = 6,
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] IO_BASE      = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  led,
    output logic        uart_tx
);

    logic [31:0]       ram [0:(1<<RAM_AW)-1];
    logic              ram_hit;
    logic              io_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic [1:0]        io_off;
    logic [31:0]       cycle;
    logic              busy;
    logic              wr_led;
    logic              wr_cycle;
    logic              wr_tx;
    logic              unused_byte_lane;

    assign ram_hit  = (addr[31:RAM_AW+2] == '0);
    assign io_hit   = (addr[31:4] == IO_BASE[31:4]);
    assign ram_idx  = addr[RAM_AW+1:2];
    assign io_off   = addr[3:2];
    assign unused_byte_lane = ^addr[1:0];

    assign wr_led   = memwrite && io_hit && (io_off == OFF_LED);
    assign wr_cycle = memwrite && io_hit && (io_off == OFF_CYCLE);
    assign wr_tx    = memwrite && io_hit && (io_off == OFF_TXDATA);

    // RAM contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (memwrite && ram_hit) begin
            ram[ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led   <= '0;
            cycle <= '0;
        end else begin
            if (wr_led) begin
                led <= writedata[7:0];
            end
            cycle <= wr_cycle ? writedata : cycle + 32'd1;
        end
    end

    uart_tx_fsm #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .reset (reset),
        .start (wr_tx),
        .data  (writedata[7:0]),
        .tx    (uart_tx),
        .busy  (busy)
    );

    always_comb begin
        readdata = '0;
        if (ram_hit) begin
            readdata = ram[ram_idx];
        end else if (io_hit) begin
            case (io_off)
                OFF_LED:    readdata = {24'b0, led};
                OFF_CYCLE:  readdata = cycle;
                OFF_STATUS: readdata = {31'b0, busy};
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - randomized self-checking bench for dmem_mmio
module tb_dmem_mmio;

    localparam int          CPB = 4;
    localparam logic [31:0] IOB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  led;
    logic        uart_tx;

    always #5 clk = ~clk;

    dmem_mmio #(
        .RAM_AW(6),
        .CLKS_PER_BIT(CPB),
        .IO_BASE(IOB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .led       (led),
        .uart_tx   (uart_tx)
    );

    int        n_checks = 0;
    int        n_errors = 0;
    bit [31:0] ram_m [64];
    bit        ram_v [64];
    bit [7:0]  led_m = 8'h00;
    bit [31:0] cyc_m = 32'h0;
    bit        busy_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return a < 32'h100;
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        return (a & 32'hFFFF_FFF0) == IOB;
    endfunction

    function automatic bit [31:0] exp_read(input logic [31:0] a);
        if (is_ram(a)) return ram_m[a[7:2]];
        if (is_io(a)) begin
            case (a[3:2])
                2'd0:    return {24'h0, led_m};
                2'd1:    return cyc_m;
                2'd3:    return {31'h0, busy_m};
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    function automatic bit can_read(input logic [31:0] a);
        return !is_ram(a) || ram_v[a[7:2]];
    endfunction

    // frame bit j: 0 start, 1..8 data LSB first, 9 stop; idle high afterwards
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        int j;
        j = k / CPB;
        if (k >= 10*CPB) return 1'b1;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // counter model: counts edges, a write replaces the increment
    always @(posedge clk or posedge reset) begin
        if (reset) cyc_m = 32'h0;
        else if (memwrite && is_io(addr) && addr[3:2] == 2'd1) cyc_m = writedata;
        else cyc_m = cyc_m + 32'd1;
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; writedata = d; memwrite = 1'b1;
        #1;
        if (can_read(a)) check("rd_during_wr", readdata, exp_read(a));
        @(posedge clk);
        if (is_ram(a)) begin
            ram_m[a[7:2]] = d;
            ram_v[a[7:2]] = 1'b1;
        end
        if (is_io(a) && a[3:2] == 2'd0) led_m = d[7:0];
        #1 memwrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input string tag, output logic [31:0] v);
        @(negedge clk);
        addr = a; memwrite = 1'b0;
        #1 v = readdata;
        check(tag, readdata, exp_read(a));
    endtask

    task automatic send_frame(input logic [7:0] b, input int rej);
        bus_write(IOB + 32'h8, {8'($urandom), 16'($urandom), b});
        for (int k = 0; k < 12*CPB; k++) begin
            @(negedge clk);
            busy_m = (k < 10*CPB);
            check("uart_tx", {31'h0, uart_tx}, {31'h0, exp_tx(b, k)});
            if (k == rej) begin
                addr = IOB + 32'h8; writedata = 32'hFF; memwrite = 1'b1;
                #1 check("txdata_rd", readdata, 32'h0);
            end else begin
                addr = IOB + 32'hC; memwrite = 1'b0;
                #1 check("status", readdata, {31'h0, busy_m});
            end
            check("led", {24'h0, led}, {24'h0, led_m});
        end
        memwrite = 1'b0;
        busy_m = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, v1, a, d;
        int          n, idx, op;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_tx", {31'h0, uart_tx}, 32'h1);
        addr = IOB + 32'h4; #1 check("rst_cycle", readdata, 32'h0);
        addr = IOB + 32'hC; #1 check("rst_status", readdata, 32'h0);
        addr = IOB;         #1 check("rst_led_rd", readdata, 32'h0);
        reset = 1'b0;

        bus_write(32'h0000_0010, 32'hDEADBEEF);
        bus_write(32'h0000_00FC, 32'h12345678);
        bus_read(32'h0000_0010, "ram_10", v);
        check("ram_10_const", v, 32'hDEADBEEF);
        bus_read(32'h0000_00FC, "ram_fc", v);
        check("ram_fc_const", v, 32'h12345678);
        bus_read(32'h0000_0100, "unmapped_100", v);
        check("unmapped_100_const", v, 32'h0);

        bus_write(IOB, 32'hFFFF_FFA5);
        check("led_a5", {24'h0, led}, 32'h0000_00A5);
        bus_read(IOB, "led_rd", v);
        check("led_rd_const", v, 32'h0000_00A5);

        bus_read(IOB + 32'h4, "cycle_a", v1);
        n = $urandom_range(1, 50);
        repeat (n - 1) @(negedge clk);
        bus_read(IOB + 32'h4, "cycle_b", v);
        check("cycle_delta", v - v1, n);

        bus_write(IOB + 32'h4, 32'hFFFF_FFFE);
        bus_read(IOB + 32'h4, "wrap0", v);
        check("wrap0_const", v, 32'hFFFF_FFFE);
        bus_read(IOB + 32'h4, "wrap1", v);
        check("wrap1_const", v, 32'hFFFF_FFFF);
        bus_read(IOB + 32'h4, "wrap2", v);
        check("wrap2_const", v, 32'h0);

        for (int i = 0; i < 300; i++) begin
            op  = $urandom_range(0, 7);
            idx = $urandom_range(0, 63);
            d   = $urandom;
            case (op)
                0: bus_write({24'h0, 6'(idx), 2'(0)}, d);
                1, 7: begin
                    a = {24'h0, 6'(idx), 2'($urandom)};
                    if (ram_v[idx]) bus_read(a, "ram_rd", v);
                    else bus_write(a, d);
                end
                2: bus_write(IOB | {30'h0, 2'($urandom)}, d);
                3: bus_read(IOB | {28'h0, 2'($urandom), 2'($urandom)}, "io_rd", v);
                4: begin
                    a = $urandom | 32'h0000_0100;
                    if (is_io(a)) a = a ^ 32'h0001_0000;
                    bus_read(a, "unmapped_rd", v);
                end
                5: begin
                    a = {16'($urandom), 8'($urandom_range(1, 255)), 6'(idx), 2'(0)};
                    if (is_io(a)) a = a ^ 32'h0001_0000;
                    bus_write(a, d);
                    if (ram_v[idx]) bus_read({24'h0, 6'(idx), 2'(0)}, "alias_rd", v);
                end
                default: bus_write(IOB + 32'h4, d);
            endcase
        end

        bus_write(IOB + 32'hC, 32'hFFFF_FFFF);
        for (int k = 0; k < 6; k++) begin
            bus_read(IOB + 32'hC, "status_wr_ignored", v);
            check("tx_idle", {31'h0, uart_tx}, 32'h1);
        end

        send_frame(8'h5A, -1);
        send_frame(8'h5A, 10);
        for (int f = 0; f < 4; f++) begin
            send_frame(8'($urandom), $urandom_range(0, 10*CPB - 1));
        end

        bus_write(IOB, {24'h0, 8'($urandom) | 8'h01});
        bus_write(IOB + 32'h8, 32'h0000_005A);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check("pre_rst_tx", {31'h0, uart_tx}, {31'h0, exp_tx(8'h5A, k)});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_tx", {31'h0, uart_tx}, 32'h1);
        check("midrst_led", {24'h0, led}, 32'h0);
        addr = IOB + 32'h4; #1 check("midrst_cycle", readdata, 32'h0);
        addr = IOB + 32'hC; #1 check("midrst_busy", readdata, 32'h0);
        led_m = 8'h00;
        busy_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_frame(8'($urandom), -1);
        bus_read(IOB + 32'h4, "post_rst_cycle", v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
